// File: rtl/digit_entry_buffer.sv
// Keypad digit-entry buffer: shift-in digits, backspace, clear, preload,
// idle auto-clear and a validated commit handshake for the alarm/time registers.
//
// state | meaning
// EMPTY | no digits entered (count == 0)
// ENTRY | partial entry (0 < count < DIGITS)
// FULL  | all slots entered (count == DIGITS)
module digit_entry_buffer #(
  parameter int DIGITS     = 4,
  parameter int DW         = 4,
  parameter int MAX_KEY    = 9,
  parameter int TIME_CHECK = 1,
  parameter int TIMEOUT    = 0
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             shift,
  input  logic [DW-1:0]                    key,
  input  logic                             back,
  input  logic                             clear,
  input  logic                             load,
  input  logic [DIGITS*DW-1:0]             load_value,
  input  logic                             commit,
  output logic [DIGITS*DW-1:0]             buffer,
  output logic [$clog2(DIGITS+1)-1:0]      count,
  output logic                             entry_active,
  output logic                             key_err,
  output logic                             commit_ok,
  output logic                             commit_err,
  output logic                             timeout
);

  localparam int CW      = $clog2(DIGITS + 1);
  localparam int TW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int BW      = DIGITS * DW;
  localparam int KEY_CAP = (MAX_KEY > (1 << DW) - 1) ? (1 << DW) - 1 : MAX_KEY;

  localparam logic [CW-1:0] FULL_CNT  = CW'(DIGITS);
  localparam logic [DW-1:0] KEY_LIMIT = DW'(KEY_CAP);
  localparam logic [TW-1:0] TO_LAST   = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {EMPTY, ENTRY, FULL} state_t;

  state_t        state, nxt_state;
  logic [BW-1:0] shifted, backed, nxt_buf;
  logic [CW-1:0] nxt_cnt;
  logic [TW-1:0] idle, nxt_idle;
  logic          nxt_key_err, nxt_commit_ok, nxt_commit_err, nxt_timeout;
  logic          time_ok, key_ok, any_op;

  assign any_op = clear | load | commit | back | shift;
  assign key_ok = (key <= KEY_LIMIT);

  always_comb begin
    shifted          = buffer << DW;
    shifted[DW-1:0]  = key;
    backed           = buffer >> DW;
  end

  // HH:MM check reads the slots as decimal digits; sized so 11*(2^DW-1) fits.
  if (TIME_CHECK != 0 && DIGITS == 4) begin : g_time
    localparam int HW = DW + 4;
    logic [HW-1:0] hours, minutes;
    assign hours   = HW'(buffer[3*DW +: DW]) * HW'(10) + HW'(buffer[2*DW +: DW]);
    assign minutes = HW'(buffer[1*DW +: DW]) * HW'(10) + HW'(buffer[0 +: DW]);
    assign time_ok = (hours <= HW'(23)) && (minutes <= HW'(59));
  end else begin : g_no_time
    assign time_ok = 1'b1;
  end

  always_comb begin
    nxt_buf        = buffer;
    nxt_cnt        = count;
    nxt_state      = state;
    nxt_idle       = idle;
    nxt_key_err    = 1'b0;
    nxt_commit_ok  = 1'b0;
    nxt_commit_err = 1'b0;
    nxt_timeout    = 1'b0;

    if (clear) begin
      nxt_buf   = '0;
      nxt_cnt   = '0;
      nxt_state = EMPTY;
    end else if (load) begin
      nxt_buf   = load_value;
      nxt_cnt   = FULL_CNT;
      nxt_state = FULL;
    end else if (commit) begin
      if (count == FULL_CNT && time_ok) begin
        nxt_commit_ok = 1'b1;
        nxt_cnt       = '0;
        nxt_state     = EMPTY;
      end else begin
        nxt_commit_err = 1'b1;
      end
    end else if (back) begin
      if (count != '0) begin
        nxt_buf   = backed;
        nxt_cnt   = count - CW'(1);
        nxt_state = (count == CW'(1)) ? EMPTY : ENTRY;
      end
    end else if (shift) begin
      if (key_ok) begin
        nxt_buf = shifted;
        if (count != FULL_CNT) nxt_cnt = count + CW'(1);
        nxt_state = (nxt_cnt == FULL_CNT) ? FULL : ENTRY;
      end else begin
        nxt_key_err = 1'b1;
      end
    end

    // An operation in the expiry cycle wins, so the timeout only fires when idle.
    if (any_op || state == EMPTY || TIMEOUT == 0) begin
      nxt_idle = '0;
    end else if (idle == TO_LAST) begin
      nxt_buf     = '0;
      nxt_cnt     = '0;
      nxt_state   = EMPTY;
      nxt_timeout = 1'b1;
      nxt_idle    = '0;
    end else begin
      nxt_idle = idle + TW'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= EMPTY;
      buffer       <= '0;
      count        <= '0;
      idle         <= '0;
      entry_active <= 1'b0;
      key_err      <= 1'b0;
      commit_ok    <= 1'b0;
      commit_err   <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      state        <= nxt_state;
      buffer       <= nxt_buf;
      count        <= nxt_cnt;
      idle         <= nxt_idle;
      entry_active <= (nxt_state != EMPTY);
      key_err      <= nxt_key_err;
      commit_ok    <= nxt_commit_ok;
      commit_err   <= nxt_commit_err;
      timeout      <= nxt_timeout;
    end
  end

endmodule

// File: tb/tb_digit_entry_buffer.sv
// Bench for digit_entry_buffer: directed scenarios plus randomized traffic
// checked against a digit-level reference model (one instance without, one with timeout).
module tb_digit_entry_buffer;

  logic        clock = 1'b0;
  logic        reset;
  logic        shift, back, clear, load, commit;
  logic [3:0]  key;
  logic [15:0] load_value;

  logic [15:0] buffer0, buffer1;
  logic [2:0]  count0, count1;
  logic        active0, active1, kerr0, kerr1, cok0, cok1, cerr0, cerr1, tout0, tout1;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [15:0] b;
    logic [2:0]  c;
    logic [7:0]  idle;
    logic        kerr, cok, cerr, tout;
  } model_t;

  model_t m0, m1;

  always #5 clock = ~clock;

  digit_entry_buffer dut (
    .clock(clock), .reset(reset), .shift(shift), .key(key), .back(back),
    .clear(clear), .load(load), .load_value(load_value), .commit(commit),
    .buffer(buffer0), .count(count0), .entry_active(active0), .key_err(kerr0),
    .commit_ok(cok0), .commit_err(cerr0), .timeout(tout0)
  );

  digit_entry_buffer #(.TIMEOUT(8)) dut_t (
    .clock(clock), .reset(reset), .shift(shift), .key(key), .back(back),
    .clear(clear), .load(load), .load_value(load_value), .commit(commit),
    .buffer(buffer1), .count(count1), .entry_active(active1), .key_err(kerr1),
    .commit_ok(cok1), .commit_err(cerr1), .timeout(tout1)
  );

  // Reference: buffer viewed as a 4-digit number that scrolls left on shift.
  function automatic model_t step(model_t s, int to, logic sh, logic [3:0] k, logic bk,
                                  logic cl, logic ld, logic [15:0] lv, logic cm);
    int hh, mm;
    logic op;
    s.kerr = 0; s.cok = 0; s.cerr = 0; s.tout = 0;
    op = sh | bk | cl | ld | cm;
    hh = s.b[15:12] * 10 + s.b[11:8];
    mm = s.b[7:4] * 10 + s.b[3:0];
    if (cl) begin
      s.b = 0; s.c = 0;
    end else if (ld) begin
      s.b = lv; s.c = 4;
    end else if (cm) begin
      if (s.c == 4 && hh <= 23 && mm <= 59) begin s.cok = 1; s.c = 0; end
      else s.cerr = 1;
    end else if (bk) begin
      if (s.c > 0) begin s.b = s.b >> 4; s.c = s.c - 1; end
    end else if (sh) begin
      if (k <= 9) begin
        s.b = {s.b[11:0], k};
        if (s.c < 4) s.c = s.c + 1;
      end else s.kerr = 1;
    end
    if (op || to == 0 || s.c == 0) s.idle = 0;
    else begin
      s.idle = s.idle + 1;
      if (int'(s.idle) == to) begin s.b = 0; s.c = 0; s.tout = 1; s.idle = 0; end
    end
    return s;
  endfunction

  task automatic cycle(input logic sh, input logic [3:0] k, input logic bk, input logic cl,
                       input logic ld, input logic [15:0] lv, input logic cm);
    shift = sh; key = k; back = bk; clear = cl; load = ld; load_value = lv; commit = cm;
    @(posedge clock);
    m0 = step(m0, 0, sh, k, bk, cl, ld, lv, cm);
    m1 = step(m1, 8, sh, k, bk, cl, ld, lv, cm);
    #1;
    shift = 0; back = 0; clear = 0; load = 0; commit = 0;
  endtask

  task automatic do_shift(input logic [3:0] k);
    cycle(1, k, 0, 0, 0, 16'h0, 0);
  endtask

  task automatic do_idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 4'h0, 0, 0, 0, 16'h0, 0);
  endtask

  task automatic apply_reset();
    reset = 1;
    m0 = '0; m1 = '0;
    @(posedge clock);
    #1 reset = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    do_shift(4'd3); do_shift(4'd7);
    reset = 1;
    #2;
    total++;
    if ({buffer0, count0, active0, kerr0, cok0, cerr0, tout0} !== 24'h0) begin
      bad++;
      $display("FAIL reset_async dut: got buf=%h cnt=%0d act=%b, want all zero", buffer0, count0, active0);
    end
    total++;
    if ({buffer1, count1, active1, kerr1, cok1, cerr1, tout1} !== 24'h0) begin
      bad++;
      $display("FAIL reset_async dut_t: got buf=%h cnt=%0d act=%b, want all zero", buffer1, count1, active1);
    end
    m0 = '0; m1 = '0;
    @(posedge clock);
    #1 reset = 0;
  endtask

  task automatic test_shift_scroll();
    apply_reset();
    do_shift(4'd1); do_shift(4'd2); do_shift(4'd3);
    total++;
    if ({buffer0, count0, active0} !== {16'h0123, 3'd3, 1'b1}) begin
      bad++; $display("FAIL shift_partial: got %h/%0d/%b want 0123/3/1", buffer0, count0, active0);
    end
    do_shift(4'd4);
    total++;
    if ({buffer0, count0, active0} !== {16'h1234, 3'd4, 1'b1}) begin
      bad++; $display("FAIL shift_full: got %h/%0d/%b want 1234/4/1", buffer0, count0, active0);
    end
    do_shift(4'd5);
    total++;
    if ({buffer0, count0, kerr0} !== {16'h2345, 3'd4, 1'b0}) begin
      bad++; $display("FAIL shift_scroll: got %h/%0d/%b want 2345/4/0", buffer0, count0, kerr0);
    end
  endtask

  task automatic test_back();
    apply_reset();
    do_shift(4'd2); do_shift(4'd3);
    cycle(0, 4'h0, 1, 0, 0, 16'h0, 0);
    total++;
    if ({buffer0, count0, active0} !== {16'h0002, 3'd1, 1'b1}) begin
      bad++; $display("FAIL back_one: got %h/%0d/%b want 0002/1/1", buffer0, count0, active0);
    end
    cycle(0, 4'h0, 1, 0, 0, 16'h0, 0);
    total++;
    if ({buffer0, count0, active0} !== {16'h0000, 3'd0, 1'b0}) begin
      bad++; $display("FAIL back_empty: got %h/%0d/%b want 0000/0/0", buffer0, count0, active0);
    end
    cycle(0, 4'h0, 1, 0, 0, 16'h0, 0);
    total++;
    if ({buffer0, count0, kerr0, cerr0, cok0} !== {16'h0000, 3'd0, 3'b000}) begin
      bad++; $display("FAIL back_noop: got %h/%0d errs=%b%b want 0000/0 no pulses", buffer0, count0, kerr0, cerr0);
    end
  endtask

  task automatic test_commit();
    apply_reset();
    do_shift(4'd2); do_shift(4'd3); do_shift(4'd5); do_shift(4'd9);
    cycle(0, 4'h0, 0, 0, 0, 16'h0, 1);
    total++;
    if ({cok0, cerr0, buffer0, count0, active0} !== {2'b10, 16'h2359, 3'd0, 1'b0}) begin
      bad++; $display("FAIL commit_ok: got ok=%b err=%b %h/%0d want ok 2359/0", cok0, cerr0, buffer0, count0);
    end
    do_idle(1);
    total++;
    if (cok0 !== 1'b0) begin
      bad++; $display("FAIL commit_ok_pulse: got %b want 0", cok0);
    end
    do_shift(4'd2); do_shift(4'd4); do_shift(4'd0); do_shift(4'd0);
    cycle(0, 4'h0, 0, 0, 0, 16'h0, 1);
    total++;
    if ({cok0, cerr0, buffer0, count0} !== {2'b01, 16'h2400, 3'd4}) begin
      bad++; $display("FAIL commit_hours: got ok=%b err=%b %h/%0d want err 2400/4", cok0, cerr0, buffer0, count0);
    end
    do_shift(4'd1); do_shift(4'd2); do_shift(4'd6); do_shift(4'd0);
    cycle(0, 4'h0, 0, 0, 0, 16'h0, 1);
    total++;
    if ({cok0, cerr0, buffer0, count0} !== {2'b01, 16'h1260, 3'd4}) begin
      bad++; $display("FAIL commit_minutes: got ok=%b err=%b %h/%0d want err 1260/4", cok0, cerr0, buffer0, count0);
    end
  endtask

  task automatic test_key_err();
    apply_reset();
    do_shift(4'd2); do_shift(4'd3);
    do_shift(4'hB);
    total++;
    if ({kerr0, buffer0, count0} !== {1'b1, 16'h0023, 3'd2}) begin
      bad++; $display("FAIL key_reject: got kerr=%b %h/%0d want 1 0023/2", kerr0, buffer0, count0);
    end
    cycle(0, 4'h0, 0, 0, 0, 16'h0, 1);
    total++;
    if ({kerr0, cok0, cerr0, count0} !== {3'b001, 3'd2}) begin
      bad++; $display("FAIL commit_partial: got kerr=%b ok=%b err=%b cnt=%0d want 0/0/1/2", kerr0, cok0, cerr0, count0);
    end
  endtask

  task automatic test_priority();
    apply_reset();
    cycle(1, 4'd5, 0, 0, 1, 16'h0730, 0);
    total++;
    if ({buffer0, count0, active0} !== {16'h0730, 3'd4, 1'b1}) begin
      bad++; $display("FAIL load_over_shift: got %h/%0d/%b want 0730/4/1", buffer0, count0, active0);
    end
    cycle(0, 4'h0, 0, 1, 0, 16'h0, 1);
    total++;
    if ({buffer0, count0, active0, cok0, cerr0} !== {16'h0000, 3'd0, 3'b000}) begin
      bad++; $display("FAIL clear_over_commit: got %h/%0d ok=%b err=%b want 0000/0 no pulse", buffer0, count0, cok0, cerr0);
    end
  endtask

  task automatic test_reset_abort();
    apply_reset();
    do_shift(4'd1); do_shift(4'd2); do_shift(4'd3); do_shift(4'd0);
    commit = 1; reset = 1;
    @(posedge clock);
    #1;
    total++;
    if ({cok0, cerr0, buffer0, count0} !== {2'b00, 16'h0000, 3'd0}) begin
      bad++; $display("FAIL reset_commit: got ok=%b %h/%0d want 0 0000/0", cok0, buffer0, count0);
    end
    commit = 0;
    m0 = '0; m1 = '0;
    reset = 0;
  endtask

  task automatic test_timeout();
    bit early;
    apply_reset();
    do_shift(4'd1);
    early = 0;
    for (int i = 0; i < 7; i++) begin
      do_idle(1);
      if (tout1 !== 1'b0 || count1 !== 3'd1) early = 1;
    end
    total++;
    if (early) begin
      bad++; $display("FAIL timeout_early: got tout=%b cnt=%0d want 0/1", tout1, count1);
    end
    do_idle(1);
    total++;
    if ({tout1, buffer1, count1, active1} !== {1'b1, 16'h0000, 3'd0, 1'b0}) begin
      bad++; $display("FAIL timeout_fire: got tout=%b %h/%0d/%b want 1 0000/0/0", tout1, buffer1, count1, active1);
    end
    do_idle(1);
    total++;
    if (tout1 !== 1'b0) begin
      bad++; $display("FAIL timeout_pulse: got %b want 0", tout1);
    end
    do_shift(4'd1);
    do_idle(7);
    do_shift(4'd2);
    total++;
    if ({tout1, buffer1, count1} !== {1'b0, 16'h0012, 3'd2}) begin
      bad++; $display("FAIL timeout_op_wins: got tout=%b %h/%0d want 0 0012/2", tout1, buffer1, count1);
    end
    do_idle(7);
    total++;
    if ({tout1, count1} !== {1'b0, 3'd2}) begin
      bad++; $display("FAIL timeout_restart: got tout=%b cnt=%0d want 0/2", tout1, count1);
    end
    do_idle(1);
    total++;
    if ({tout1, count1} !== {1'b1, 3'd0}) begin
      bad++; $display("FAIL timeout_second: got tout=%b cnt=%0d want 1/0", tout1, count1);
    end
  endtask

  task automatic test_random();
    logic sh, bk, cl, ld, cm;
    logic [3:0] k;
    logic [15:0] lv;
    int r;
    apply_reset();
    for (int n = 0; n < 800; n++) begin
      {sh, bk, cl, ld, cm} = 5'b0;
      k  = 4'($urandom_range(0, 11));
      lv = {4'($urandom_range(0, 2)), 4'($urandom_range(0, 9)),
            4'($urandom_range(0, 6)), 4'($urandom_range(0, 9))};
      if ($urandom_range(0, 9) == 0) begin
        {sh, bk, cl, ld, cm} = 5'($urandom);
      end else begin
        r = $urandom_range(0, 29);
        if (r == 0) cl = 1;
        else if (r == 1) ld = 1;
        else if (r <= 3) cm = 1;
        else if (r <= 5) bk = 1;
        else if (r <= 9) sh = 1;
      end
      cycle(sh, k, bk, cl, ld, lv, cm);
      total++;
      if ({buffer0, count0, active0, kerr0, cok0, cerr0, tout0} !==
          {m0.b, m0.c, m0.c != 3'd0, m0.kerr, m0.cok, m0.cerr, m0.tout}) begin
        bad++;
        $display("FAIL random_dut[%0d]: got %h/%0d/%b k%b o%b e%b t%b want %h/%0d k%b o%b e%b t%b",
                 n, buffer0, count0, active0, kerr0, cok0, cerr0, tout0,
                 m0.b, m0.c, m0.kerr, m0.cok, m0.cerr, m0.tout);
      end
      total++;
      if ({buffer1, count1, active1, kerr1, cok1, cerr1, tout1} !==
          {m1.b, m1.c, m1.c != 3'd0, m1.kerr, m1.cok, m1.cerr, m1.tout}) begin
        bad++;
        $display("FAIL random_dut_t[%0d]: got %h/%0d/%b k%b o%b e%b t%b want %h/%0d k%b o%b e%b t%b",
                 n, buffer1, count1, active1, kerr1, cok1, cerr1, tout1,
                 m1.b, m1.c, m1.kerr, m1.cok, m1.cerr, m1.tout);
      end
    end
  endtask

  initial begin
    reset = 1;
    {shift, back, clear, load, commit} = 5'b0;
    key = 4'h0;
    load_value = 16'h0;
    m0 = '0; m1 = '0;
    #2;
    total++;
    if ({buffer0, count0, active0, kerr0, cok0, cerr0, tout0} !== 24'h0) begin
      bad++; $display("FAIL reset_initial: got buf=%h cnt=%0d act=%b want zero", buffer0, count0, active0);
    end
    test_reset();
    test_shift_scroll();
    test_back();
    test_commit();
    test_key_err();
    test_priority();
    test_reset_abort();
    test_timeout();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
